mem_bus: RTL
============

MEM_BUS -- requirements
Module: mem_bus

Interface
REQ-001 Parameter RAM_WORDS, default 4096, number of 32-bit RAM words mapped from byte address 0x0000.
REQ-002 Parameter CLK_DIV, default 104, clk cycles per UART bit.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-005 rd_en  input  1  read request strobe from CPU, one cycle per request.
REQ-006 addr  input  16  byte address of current request; bits [1:0] ignored.
REQ-007 rd_data  output  32  read data.
REQ-008 rd_valid  output  1  read data valid, one-cycle pulse.
REQ-009 wr_en  input  1  write request strobe, one cycle per request.
REQ-010 wr_data  input  32  write data.
REQ-011 uart_tx  output  1  UART serial line, 8N1, idle high.
REQ-012 led  output  8  debug LED register.

Function
REQ-013 Address map: 0x0000..RAM_WORDS*4-1 RAM; 0x8000 UART; 0x8004 LED; 0x8008 TIMER; all else unmapped.
REQ-014 Read latency exactly one cycle: rd_en in cycle N -> rd_valid=1 and rd_data valid in cycle N+1.
REQ-015 rd_valid high for exactly one cycle per accepted rd_en; back-to-back rd_en in consecutive cycles yields rd_valid in consecutive cycles.
REQ-016 rd_data holds its last value while rd_valid=0.
REQ-017 Writes complete in the cycle wr_en is sampled; a read of the same address in the next cycle returns the new value.
REQ-018 rd_en and wr_en both high in the same cycle: write performed, read ignored, no rd_valid.
REQ-019 RAM: full 32-bit word read/write at addr[15:2]; no byte enables.
REQ-020 Unmapped read returns 0x00000000 with rd_valid; unmapped write has no effect.
REQ-021 LED write: led <= wr_data[7:0]; LED read returns {24'b0, led}.
REQ-022 TIMER: 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF -> 0; write loads wr_data, increments resume next cycle; read returns value sampled in the rd_en cycle.
REQ-023 UART read returns {31'b0, busy}.
REQ-024 UART write while idle: latch wr_data[7:0], busy=1 from next cycle; write while busy ignored, byte dropped.
REQ-025 UART FSM states IDLE, START, DATA, STOP; IDLE->START on accepted write; START (tx=0) CLK_DIV cycles; DATA 8 bits LSB first, CLK_DIV cycles each; STOP (tx=1) CLK_DIV cycles; then IDLE, busy=0.
REQ-026 Frame length exactly 10*CLK_DIV cycles from first START cycle to busy deassertion.
REQ-027 Bit counter 0..7 and divider 0..CLK_DIV-1 wrap to 0 on each transition.

Reset
REQ-028 On rst: rd_valid=0, rd_data=0, led=0, timer=0, uart_tx=1, busy=0, UART FSM=IDLE, counters=0.
REQ-029 rst mid-frame aborts transmission; uart_tx=1 from the cycle after rst sampled.
REQ-030 rst has priority over rd_en/wr_en in the same cycle; requests during rst are discarded.
REQ-031 RAM contents not affected by rst.

Structure
REQ-032 Shared package mem_bus_pkg holds address-map constants (RAM base, UART, LED, TIMER addresses) and UART state enum.
REQ-033 UART transmitter is one sub-module, uart_tx, with ports clk, rst, start, data[7:0], busy, tx.
REQ-034 RAM inferable as single-port synchronous block RAM.

Verification
REQ-035 Write 0xDEADBEEF to 0x0084, rd_en 0x0084 next cycle -> rd_valid next cycle, rd_data=0xDEADBEEF.
REQ-036 rd_en on 0x0000, 0x0004, 0x0008 in three consecutive cycles -> three consecutive rd_valid pulses, data in order.
REQ-037 Write 0x55 to 0x8000, CLK_DIV=4 -> uart_tx 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop 1; busy reads 1 during, 0 after 40 cycles.
REQ-038 Second UART write during busy -> ignored, single frame only; rst mid-frame -> uart_tx=1, busy=0 next cycle.
REQ-039 Write 0xFFFFFFFE to 0x8008 -> reads two cycles apart show wrap through 0; read 0xC000 -> 0, write 0xC000 no effect.
REQ-040 rd_en and wr_en together at 0x8004 with wr_data=0xA5 -> led=0xA5, no rd_valid.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the mem_bus slice: the address map and
// the UART transmitter state encoding.
package mem_bus_pkg;

  localparam logic [15:0] RAM_BASE   = 16'h0000;
  localparam logic [15:0] UART_ADDR  = 16'h8000;
  localparam logic [15:0] LED_ADDR   = 16'h8004;
  localparam logic [15:0] TIMER_ADDR = 16'h8008;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uartState_e;

endpackage

// File: rtl/mem_bus_if.sv
// CPU-side request/response bundle; the CPU drives the master side and
// mem_bus sits on the slave side.
interface mem_bus_if;

  logic        rd_en;
  logic [15:0] addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        wr_en;
  logic [31:0] wr_data;

  modport master (
    output rd_en, addr, wr_en, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  rd_en, addr, wr_en, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/mem_bus_uart_tx.sv
// 8N1 UART transmitter, one byte per start pulse; start is only honoured
// while idle, so a pulse during a frame is simply dropped.
module uart_tx
  import mem_bus_pkg::*;
#(
  parameter int CLK_DIV = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       busy,
  output logic       tx
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  uartState_e    state_q;
  logic [DW-1:0] div_q;
  logic [2:0]    bitCnt_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          busy_q;

  // tx and busy are registered with the state so the line never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UART_IDLE;
      div_q    <= '0;
      bitCnt_q <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        UART_IDLE: begin
          if (start) begin
            state_q  <= UART_START;
            shift_q  <= data;
            div_q    <= '0;
            bitCnt_q <= '0;
            tx_q     <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        UART_START: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            state_q <= UART_DATA;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[7:1]};
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        UART_DATA: begin
          if (div_q == DIV_LAST) begin
            div_q <= '0;
            if (bitCnt_q == 3'd7) begin
              bitCnt_q <= '0;
              state_q  <= UART_STOP;
              tx_q     <= 1'b1;
            end else begin
              bitCnt_q <= bitCnt_q + 1'b1;
              tx_q     <= shift_q[0];
              shift_q  <= {1'b0, shift_q[7:1]};
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        UART_STOP: begin
          if (div_q == DIV_LAST) begin
            div_q   <= '0;
            state_q <= UART_IDLE;
            busy_q  <= 1'b0;
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= UART_IDLE;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/mem_bus.sv
// Memory-mapped bus: word RAM at the bottom of the map plus UART, LED and
// free-running timer registers, all answered with one cycle of read latency.
module mem_bus
  import mem_bus_pkg::*;
#(
  parameter int RAM_WORDS = 4096,
  parameter int CLK_DIV   = 104
) (
  input  logic       clk,
  input  logic       rst,
  mem_bus_if.slave   bus,
  output logic       uart_tx,
  output logic [7:0] led
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) * 32'd4;

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   ramQ;
  logic [31:0]   ramOffset;
  logic [AW-1:0] ramIdx;

  logic        isRam, isUart, isLed, isTimer;
  logic        readAccept, ramWe, uartStart, uartBusy;
  logic [31:0] regReadData;
  logic [31:0] rdDataMux;

  logic        rdValid_q;
  logic        readRam_q;
  logic [31:0] regData_q;
  logic [31:0] holdData_q;
  logic [7:0]  led_q, led_d;
  logic [31:0] timer_q, timer_d;

  always_comb begin
    ramOffset = {16'b0, bus.addr} - {16'b0, RAM_BASE};
    isRam     = (ramOffset < RAM_BYTES);
    ramIdx    = ramOffset[AW+1:2];
    isUart    = (bus.addr[15:2] == UART_ADDR[15:2]);
    isLed     = (bus.addr[15:2] == LED_ADDR[15:2]);
    isTimer   = (bus.addr[15:2] == TIMER_ADDR[15:2]);

    // A simultaneous write wins; the read half of that cycle is discarded.
    readAccept = bus.rd_en && !bus.wr_en;
    ramWe      = bus.wr_en && isRam && !rst;
    uartStart  = bus.wr_en && isUart && !uartBusy && !rst;

    regReadData = 32'h0;
    if (isUart) begin
      regReadData = {31'b0, uartBusy};
    end else if (isLed) begin
      regReadData = {24'b0, led_q};
    end else if (isTimer) begin
      regReadData = timer_q;
    end

    led_d   = (bus.wr_en && isLed) ? bus.wr_data[7:0] : led_q;
    timer_d = (bus.wr_en && isTimer) ? bus.wr_data : timer_q + 32'd1;
  end

  // Kept reset-free and single-ported so it maps onto a block RAM.
  always_ff @(posedge clk) begin
    if (ramWe) begin
      ram[ramIdx] <= bus.wr_data;
    end
    ramQ <= ram[ramIdx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdValid_q  <= 1'b0;
      readRam_q  <= 1'b0;
      regData_q  <= 32'h0;
      holdData_q <= 32'h0;
      led_q      <= 8'h0;
      timer_q    <= 32'h0;
    end else begin
      rdValid_q <= readAccept;
      if (readAccept) begin
        readRam_q <= isRam;
        regData_q <= isRam ? 32'h0 : regReadData;
      end
      if (rdValid_q) begin
        holdData_q <= rdDataMux;
      end
      led_q   <= led_d;
      timer_q <= timer_d;
    end
  end

  assign rdDataMux    = readRam_q ? ramQ : regData_q;
  assign bus.rd_data  = rdValid_q ? rdDataMux : holdData_q;
  assign bus.rd_valid = rdValid_q;
  assign led          = led_q;

  uart_tx #(
    .CLK_DIV(CLK_DIV)
  ) uTx (
    .clk  (clk),
    .rst  (rst),
    .start(uartStart),
    .data (bus.wr_data[7:0]),
    .busy (uartBusy),
    .tx   (uart_tx)
  );

endmodule
